// File: rtl/counter_arb_pkg.sv
// Shared types and defaults for the round-robin scheduled counter.
package counter_arb_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultNReq  = 2;

  localparam logic [1:0] IdleEnc  = 2'd0;
  localparam logic [1:0] CountEnc = 2'd1;
  localparam logic [1:0] DoneEnc  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IdleEnc,
    StCount = CountEnc,
    StDone  = DoneEnc
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    sel      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (idx >= (IDX_W + 1)'(N_REQ)) begin
        idx = idx - (IDX_W + 1)'(N_REQ);
      end
      sel = idx[IDX_W-1:0];
      if (!found && req[sel]) begin
        found     = 1'b1;
        pick[sel] = 1'b1;
        pick_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// One shared up-counter time-sliced between requesters; each grant counts len+1 ticks
// and ends with a one-cycle done pulse to the owner.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N_REQ = DefaultNReq
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  input  logic                   en,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  pick;
  logic [IdxW-1:0]   pick_idx;
  logic [WIDTH-1:0]  len_slice [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_arbiter (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      len_slice[i] = len[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    target_d = target_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      StIdle: begin
        q_d = '0;
        if (|pick) begin
          owner_d  = pick_idx;
          target_d = len_slice[pick_idx];
          state_d  = StCount;
        end
      end
      StCount: begin
        // Dropping req aborts even while stalled.
        if (!req[owner_q]) begin
          state_d = StIdle;
          q_d     = '0;
          ptr_d   = owner_q;
        end else if (en) begin
          if (q_q == target_q) begin
            state_d = StDone;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        q_d     = '0;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      q_q      <= '0;
      target_q <= '0;
      owner_q  <= '0;
      ptr_q    <= IdxW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    if (state_q != StIdle) begin
      grant[owner_q] = 1'b1;
    end
    if (state_q == StDone) begin
      done[owner_q] = 1'b1;
    end
  end

  assign busy = (state_q != StIdle);
  assign q    = q_q;

endmodule
